// File: rtl/simplebus_pkg.sv
// SimpleBus command encodings, field widths and arbiter state type.
package simplebus_pkg;

    localparam int unsigned AddrW = 32;
    localparam int unsigned SizeW = 3;
    localparam int unsigned CmdW  = 4;
    localparam int unsigned MaskW = 8;
    localparam int unsigned DataW = 64;
    localparam int unsigned UserW = 16;

    localparam logic [CmdW-1:0] CmdRead       = 4'b0000;
    localparam logic [CmdW-1:0] CmdWrite      = 4'b0001;
    localparam logic [CmdW-1:0] CmdReadBurst  = 4'b0010;
    localparam logic [CmdW-1:0] CmdWriteBurst = 4'b0011;
    localparam logic [CmdW-1:0] CmdWriteResp  = 4'b0101;
    localparam logic [CmdW-1:0] CmdReadLast   = 4'b0110;
    localparam logic [CmdW-1:0] CmdWriteLast  = 4'b0111;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StResp
    } arb_state_e;

    // A response beat with one of these commands closes the transaction.
    function automatic logic resp_is_final(input logic [CmdW-1:0] cmd);
        return (cmd == CmdReadLast) || (cmd == CmdWriteResp);
    endfunction

endpackage

// File: rtl/simplebus_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request scanning upward from ptr_i, wrapping.
module simplebus_arbiter_rr_pick #(
    parameter int unsigned NM  = 2,
    parameter int unsigned IDW = 1
) (
    input  logic [NM-1:0]  req_i,
    input  logic [IDW-1:0] ptr_i,
    output logic [IDW-1:0] gnt_id_o,
    output logic           any_o
);

    logic [31:0] idx;

    always_comb begin
        gnt_id_o = '0;
        any_o    = 1'b0;
        idx      = '0;
        for (int unsigned i = 0; i < NM; i++) begin
            idx = 32'(ptr_i) + i;
            if (idx >= NM) begin
                idx = idx - NM;
            end
            if (!any_o && req_i[idx[IDW-1:0]]) begin
                any_o    = 1'b1;
                gnt_id_o = idx[IDW-1:0];
            end
        end
    end

endmodule

// File: rtl/simplebus_arbiter.sv
// N-master to 1-slave SimpleBus arbiter; round-robin, one transaction in flight, grant held
// from the first request beat to the final response beat.
module simplebus_arbiter
    import simplebus_pkg::*;
#(
    parameter int unsigned NM  = 2,
    parameter int unsigned IDW = (NM > 1) ? $clog2(NM) : 1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NM-1:0]            m_req_valid,
    output logic [NM-1:0]            m_req_ready,
    input  logic [NM-1:0][AddrW-1:0] m_req_addr,
    input  logic [NM-1:0][SizeW-1:0] m_req_size,
    input  logic [NM-1:0][CmdW-1:0]  m_req_cmd,
    input  logic [NM-1:0][MaskW-1:0] m_req_wmask,
    input  logic [NM-1:0][DataW-1:0] m_req_wdata,
    input  logic [NM-1:0][UserW-1:0] m_req_user,
    output logic [NM-1:0]            m_resp_valid,
    input  logic [NM-1:0]            m_resp_ready,
    output logic [CmdW-1:0]          m_resp_cmd,
    output logic [DataW-1:0]         m_resp_rdata,
    output logic [UserW-1:0]         m_resp_user,
    output logic                     s_req_valid,
    output logic [AddrW-1:0]         s_req_addr,
    output logic [SizeW-1:0]         s_req_size,
    output logic [CmdW-1:0]          s_req_cmd,
    output logic [MaskW-1:0]         s_req_wmask,
    output logic [DataW-1:0]         s_req_wdata,
    output logic [UserW-1:0]         s_req_user,
    input  logic                     s_req_ready,
    input  logic                     s_resp_valid,
    input  logic [CmdW-1:0]          s_resp_cmd,
    input  logic [DataW-1:0]         s_resp_rdata,
    input  logic [UserW-1:0]         s_resp_user,
    output logic                     s_resp_ready,
    output logic [IDW-1:0]           grant_id,
    output logic                     busy,
    output logic                     stray_resp
);

    arb_state_e     state_q;
    logic [IDW-1:0] grant_id_q;
    logic [IDW-1:0] rr_ptr_q;
    logic [IDW-1:0] pick_id;
    logic           pick_any;
    logic [IDW-1:0] next_ptr;

    simplebus_arbiter_rr_pick #(
        .NM  (NM),
        .IDW (IDW)
    ) u_rr_pick (
        .req_i    (m_req_valid),
        .ptr_i    (rr_ptr_q),
        .gnt_id_o (pick_id),
        .any_o    (pick_any)
    );

    assign next_ptr = (pick_id == IDW'(NM - 1)) ? '0 : pick_id + 1'b1;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= StIdle;
            grant_id_q <= '0;
            rr_ptr_q   <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (pick_any) begin
                        grant_id_q <= pick_id;
                        rr_ptr_q   <= next_ptr;
                        state_q    <= StReq;
                    end
                end
                StReq: begin
                    // Write bursts keep the request channel open for further beats.
                    if (s_req_valid && s_req_ready && (s_req_cmd != CmdWriteBurst)) begin
                        state_q <= StResp;
                    end
                end
                StResp: begin
                    if (s_resp_valid && s_resp_ready && resp_is_final(s_resp_cmd)) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Request channel: owner's fields pass straight through, valid gated by state.
    always_comb begin
        s_req_valid = (state_q == StReq) && m_req_valid[grant_id_q];
        s_req_addr  = m_req_addr[grant_id_q];
        s_req_size  = m_req_size[grant_id_q];
        s_req_cmd   = m_req_cmd[grant_id_q];
        s_req_wmask = m_req_wmask[grant_id_q];
        s_req_wdata = m_req_wdata[grant_id_q];
        s_req_user  = m_req_user[grant_id_q];
        m_req_ready = '0;
        if (state_q == StReq) begin
            m_req_ready[grant_id_q] = s_req_ready;
        end
    end

    always_comb begin
        m_resp_valid = '0;
        s_resp_ready = 1'b0;
        if (state_q == StResp) begin
            m_resp_valid[grant_id_q] = s_resp_valid;
            s_resp_ready             = m_resp_ready[grant_id_q];
        end
    end

    assign m_resp_cmd   = s_resp_cmd;
    assign m_resp_rdata = s_resp_rdata;
    assign m_resp_user  = s_resp_user;

    assign grant_id   = grant_id_q;
    assign busy       = (state_q != StIdle);
    assign stray_resp = s_resp_valid && (state_q != StResp);

endmodule

// File: tb/tb_simplebus_arbiter.sv
// Directed bench for simplebus_arbiter with two masters and a hand-driven slave.
module tb_simplebus_arbiter;

    localparam logic [3:0] CRead       = 4'b0000;
    localparam logic [3:0] CReadBurst  = 4'b0010;
    localparam logic [3:0] CWriteBurst = 4'b0011;
    localparam logic [3:0] CWriteResp  = 4'b0101;
    localparam logic [3:0] CReadLast   = 4'b0110;
    localparam logic [3:0] CWriteLast  = 4'b0111;

    logic             clock;
    logic             reset;
    logic [1:0]       m_req_valid;
    logic [1:0]       m_req_ready;
    logic [1:0][31:0] m_req_addr;
    logic [1:0][2:0]  m_req_size;
    logic [1:0][3:0]  m_req_cmd;
    logic [1:0][7:0]  m_req_wmask;
    logic [1:0][63:0] m_req_wdata;
    logic [1:0][15:0] m_req_user;
    logic [1:0]       m_resp_valid;
    logic [1:0]       m_resp_ready;
    logic [3:0]       m_resp_cmd;
    logic [63:0]      m_resp_rdata;
    logic [15:0]      m_resp_user;
    logic             s_req_valid;
    logic [31:0]      s_req_addr;
    logic [2:0]       s_req_size;
    logic [3:0]       s_req_cmd;
    logic [7:0]       s_req_wmask;
    logic [63:0]      s_req_wdata;
    logic [15:0]      s_req_user;
    logic             s_req_ready;
    logic             s_resp_valid;
    logic [3:0]       s_resp_cmd;
    logic [63:0]      s_resp_rdata;
    logic [15:0]      s_resp_user;
    logic             s_resp_ready;
    logic [0:0]       grant_id;
    logic             busy;
    logic             stray_resp;

    int checks = 0;
    int failures = 0;

    simplebus_arbiter #(
        .NM  (2),
        .IDW (1)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .m_req_valid  (m_req_valid),
        .m_req_ready  (m_req_ready),
        .m_req_addr   (m_req_addr),
        .m_req_size   (m_req_size),
        .m_req_cmd    (m_req_cmd),
        .m_req_wmask  (m_req_wmask),
        .m_req_wdata  (m_req_wdata),
        .m_req_user   (m_req_user),
        .m_resp_valid (m_resp_valid),
        .m_resp_ready (m_resp_ready),
        .m_resp_cmd   (m_resp_cmd),
        .m_resp_rdata (m_resp_rdata),
        .m_resp_user  (m_resp_user),
        .s_req_valid  (s_req_valid),
        .s_req_addr   (s_req_addr),
        .s_req_size   (s_req_size),
        .s_req_cmd    (s_req_cmd),
        .s_req_wmask  (s_req_wmask),
        .s_req_wdata  (s_req_wdata),
        .s_req_user   (s_req_user),
        .s_req_ready  (s_req_ready),
        .s_resp_valid (s_resp_valid),
        .s_resp_cmd   (s_resp_cmd),
        .s_resp_rdata (s_resp_rdata),
        .s_resp_user  (s_resp_user),
        .s_resp_ready (s_resp_ready),
        .grant_id     (grant_id),
        .busy         (busy),
        .stray_resp   (stray_resp)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    task automatic test_reset();
        reset        = 1'b1;
        m_req_valid  = 2'b11;
        m_req_addr   = '0;
        m_req_size   = '0;
        m_req_cmd    = '0;
        m_req_wmask  = '0;
        m_req_wdata  = '0;
        m_req_user   = '0;
        m_resp_ready = 2'b11;
        s_req_ready  = 1'b1;
        s_resp_valid = 1'b0;
        s_resp_cmd   = '0;
        s_resp_rdata = '0;
        s_resp_user  = '0;
        repeat (3) @(negedge clock);
        #1;
        checks++; if (busy !== 1'b0) begin failures++;
            $display("FAIL reset_busy: got %0h want 0", busy); end
        checks++; if (grant_id !== 1'b0) begin failures++;
            $display("FAIL reset_grant: got %0h want 0", grant_id); end
        checks++; if (m_req_ready !== 2'b00) begin failures++;
            $display("FAIL reset_m_req_ready: got %0h want 0", m_req_ready); end
        checks++; if (m_resp_valid !== 2'b00) begin failures++;
            $display("FAIL reset_m_resp_valid: got %0h want 0", m_resp_valid); end
        checks++; if (s_req_valid !== 1'b0 || s_resp_ready !== 1'b0) begin failures++;
            $display("FAIL reset_slave_side: got %0h/%0h want 0/0", s_req_valid, s_resp_ready); end
        @(negedge clock);
        reset       = 1'b0;
        m_req_valid = 2'b00;
    endtask

    task automatic test_single_read();
        @(negedge clock);
        m_req_valid   = 2'b10;
        m_req_addr[1] = 32'h8000_0000;
        m_req_cmd[1]  = CRead;
        m_req_user[1] = 16'h00A1;
        s_req_ready   = 1'b1;
        #1;
        checks++; if (busy !== 1'b0 || m_req_ready !== 2'b00) begin failures++;
            $display("FAIL read_bubble: got busy=%0h rdy=%0h want 0/0", busy, m_req_ready); end
        @(negedge clock);
        #1;
        checks++; if (grant_id !== 1'b1 || busy !== 1'b1) begin failures++;
            $display("FAIL read_grant: got id=%0h busy=%0h want 1/1", grant_id, busy); end
        checks++; if (s_req_valid !== 1'b1 || s_req_addr !== 32'h8000_0000) begin failures++;
            $display("FAIL read_s_req: got v=%0h a=%0h want 1/80000000", s_req_valid, s_req_addr); end
        checks++; if (m_req_ready !== 2'b10 || s_req_user !== 16'h00A1) begin failures++;
            $display("FAIL read_ready_user: got %0h/%0h want 2/a1", m_req_ready, s_req_user); end
        @(negedge clock);
        m_req_valid  = 2'b00;
        s_req_ready  = 1'b0;
        s_resp_valid = 1'b1;
        s_resp_cmd   = CReadLast;
        s_resp_rdata = 64'hDEAD_BEEF_0000_0001;
        s_resp_user  = 16'h0BEE;
        m_resp_ready = 2'b11;
        #1;
        checks++; if (m_resp_valid !== 2'b10 || s_resp_ready !== 1'b1) begin failures++;
            $display("FAIL read_resp_route: got v=%0h r=%0h want 2/1", m_resp_valid, s_resp_ready); end
        checks++; if (m_resp_rdata !== 64'hDEAD_BEEF_0000_0001 || m_resp_user !== 16'h0BEE)
            begin failures++;
            $display("FAIL read_resp_data: got %0h/%0h want deadbeef00000001/bee",
                     m_resp_rdata, m_resp_user); end
        @(negedge clock);
        s_resp_valid = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || stray_resp !== 1'b0) begin failures++;
            $display("FAIL read_done: got busy=%0h stray=%0h want 0/0", busy, stray_resp); end
    endtask

    task automatic test_round_robin();
        logic exp_id;
        m_req_cmd[0] = CRead;
        m_req_cmd[1] = CRead;
        s_req_ready  = 1'b1;
        for (int t = 0; t < 6; t++) begin
            exp_id = (t % 2 == 1);
            @(negedge clock);
            m_req_valid  = 2'b11;
            s_resp_valid = 1'b0;
            @(negedge clock);
            #1;
            checks++; if (grant_id !== exp_id || busy !== 1'b1) begin failures++;
                $display("FAIL rr_grant_%0d: got %0h want %0h", t, grant_id, exp_id); end
            @(negedge clock);
            s_resp_valid = 1'b1;
            s_resp_cmd   = CReadLast;
            s_resp_rdata = 64'(t);
            #1;
            checks++; if (m_resp_valid !== (2'b01 << exp_id)) begin failures++;
                $display("FAIL rr_resp_%0d: got %0h want %0h", t, m_resp_valid, 2'b01 << exp_id); end
        end
        @(negedge clock);
        m_req_valid  = 2'b00;
        s_resp_valid = 1'b0;
    endtask

    task automatic test_write_burst();
        @(negedge clock);
        m_req_valid  = 2'b11;
        m_req_cmd[1] = CRead;
        m_req_cmd[0] = CWriteBurst;
        s_req_ready  = 1'b1;
        for (int b = 0; b < 4; b++) begin
            @(negedge clock);
            m_req_cmd[0]   = (b < 3) ? CWriteBurst : CWriteLast;
            m_req_wdata[0] = 64'h1000 + 64'(b);
            #1;
            checks++; if (grant_id !== 1'b0 || m_req_ready !== 2'b01) begin failures++;
                $display("FAIL wb_owner_%0d: got id=%0h rdy=%0h want 0/1", b, grant_id, m_req_ready);
            end
            checks++; if (s_req_valid !== 1'b1 || s_req_wdata !== 64'h1000 + 64'(b)) begin failures++;
                $display("FAIL wb_beat_%0d: got v=%0h d=%0h want 1/%0h", b, s_req_valid,
                         s_req_wdata, 64'h1000 + 64'(b)); end
        end
        @(negedge clock);
        m_req_valid  = 2'b10;
        s_resp_valid = 1'b1;
        s_resp_cmd   = CWriteResp;
        #1;
        checks++; if (m_resp_valid !== 2'b01 || m_req_ready !== 2'b00) begin failures++;
            $display("FAIL wb_resp: got v=%0h rdy=%0h want 1/0", m_resp_valid, m_req_ready); end
        @(negedge clock);
        s_resp_valid = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin failures++;
            $display("FAIL wb_idle: got busy=%0h want 0", busy); end
        @(negedge clock);
        #1;
        checks++; if (grant_id !== 1'b1 || busy !== 1'b1) begin failures++;
            $display("FAIL wb_next_grant: got id=%0h busy=%0h want 1/1", grant_id, busy); end
        @(negedge clock);
        m_req_valid  = 2'b00;
        s_resp_valid = 1'b1;
        s_resp_cmd   = CReadLast;
        @(negedge clock);
        s_resp_valid = 1'b0;
    endtask

    task automatic test_read_burst();
        logic [3:0] cmds [4];
        int k;
        cmds[0] = CReadBurst; cmds[1] = CReadBurst; cmds[2] = CReadBurst; cmds[3] = CReadLast;
        k = 0;
        @(negedge clock);
        m_req_valid  = 2'b01;
        m_req_cmd[0] = CReadBurst;
        s_req_ready  = 1'b1;
        @(negedge clock);
        @(negedge clock);
        m_req_valid = 2'b00;
        for (int c = 0; c < 20 && k < 4; c++) begin
            if (c > 0) @(negedge clock);
            s_resp_valid    = 1'b1;
            s_resp_cmd      = cmds[k];
            s_resp_rdata    = 64'hA0 + 64'(k);
            m_resp_ready[0] = c[0];
            #1;
            checks++; if (s_resp_ready !== m_resp_ready[0] || m_resp_valid !== 2'b01) begin
                failures++;
                $display("FAIL rb_ready_mirror_%0d: got r=%0h v=%0h want %0h/1", c, s_resp_ready,
                         m_resp_valid, m_resp_ready[0]); end
            if (m_resp_ready[0]) begin
                checks++; if (m_resp_rdata !== 64'hA0 + 64'(k)) begin failures++;
                    $display("FAIL rb_beat_%0d: got %0h want %0h", k, m_resp_rdata,
                             64'hA0 + 64'(k)); end
                k++;
            end
        end
        checks++; if (k !== 4) begin failures++;
            $display("FAIL rb_beat_count: got %0d want 4", k); end
        @(negedge clock);
        s_resp_valid = 1'b0;
        m_resp_ready = 2'b11;
        #1;
        checks++; if (busy !== 1'b0) begin failures++;
            $display("FAIL rb_done: got busy=%0h want 0", busy); end
    endtask

    task automatic test_stray_mid_reset();
        @(negedge clock);
        s_resp_valid = 1'b1;
        s_resp_cmd   = CReadLast;
        #1;
        checks++; if (stray_resp !== 1'b1 || m_resp_valid !== 2'b00 || s_resp_ready !== 1'b0)
            begin failures++;
            $display("FAIL stray_idle: got s=%0h v=%0h r=%0h want 1/0/0", stray_resp,
                     m_resp_valid, s_resp_ready); end
        @(negedge clock);
        s_resp_valid = 1'b0;
        #1;
        checks++; if (stray_resp !== 1'b0) begin failures++;
            $display("FAIL stray_clear: got %0h want 0", stray_resp); end
        m_req_valid  = 2'b10;
        m_req_cmd[1] = CRead;
        s_req_ready  = 1'b1;
        @(negedge clock);
        @(negedge clock);
        m_req_valid  = 2'b00;
        s_resp_valid = 1'b1;
        s_resp_cmd   = CReadBurst;
        m_resp_ready = 2'b00;
        #1;
        checks++; if (busy !== 1'b1 || m_resp_valid !== 2'b10 || stray_resp !== 1'b0) begin
            failures++;
            $display("FAIL mid_resp_state: got b=%0h v=%0h s=%0h want 1/2/0", busy,
                     m_resp_valid, stray_resp); end
        reset = 1'b1;
        @(negedge clock);
        #1;
        checks++; if (busy !== 1'b0 || grant_id !== 1'b0 || m_resp_valid !== 2'b00) begin
            failures++;
            $display("FAIL mid_reset: got b=%0h id=%0h v=%0h want 0/0/0", busy, grant_id,
                     m_resp_valid); end
        checks++; if (stray_resp !== 1'b1) begin failures++;
            $display("FAIL mid_reset_stray: got %0h want 1", stray_resp); end
        reset        = 1'b0;
        s_resp_valid = 1'b0;
        m_resp_ready = 2'b11;
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_round_robin();
        test_write_burst();
        test_read_burst();
        test_stray_mid_reset();
        repeat (2) @(negedge clock);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
